// File: rtl/dcache_assoc_pkg.sv
// Shared types and helpers for the set-associative write-back data cache.
// Holds the controller state encoding, the default geometry with its derived
// field widths, and the line-alignment helper used to build memory addresses.
package dcache_assoc_pkg;

    // Controller states: lookup, dirty-victim writeback, line fetch, line install
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        REFILL    = 2'd3
    } cache_state_t;

    // Default geometry of the cache
    localparam int DEF_WAYS      = 2;
    localparam int DEF_SETS      = 16;
    localparam int DEF_LINE_BITS = 256;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_WORD_W    = 32;

    // Address field widths of the default geometry
    localparam int OFFSET_W   = $clog2(DEF_LINE_BITS / 8);
    localparam int INDEX_W    = $clog2(DEF_SETS);
    localparam int TAG_W      = DEF_ADDR_W - INDEX_W - OFFSET_W;
    localparam int AGE_W      = $clog2(DEF_WAYS);
    localparam int WORD_SEL_W = OFFSET_W - 2;

    // Clears the byte-offset bits so the address points at the start of its line
    function automatic logic [63:0] line_align(input logic [63:0] addr, input int offset_w);
        logic [63:0] mask;
        mask = ~((64'd1 << offset_w) - 64'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/dcache_lru_set.sv
// Per-set LRU age tracking for the associative data cache.
// Every set keeps one age per way; the ages of a set always form a permutation
// of 0..WAYS-1, so the way whose age is WAYS-1 is the least recently used one.
// The victim output prefers the lowest-index invalid way of the queried set.
module dcache_lru_set #(
    parameter int WAYS    = 2,
    parameter int SETS    = 16,
    parameter int WAY_W   = 1,
    parameter int INDEX_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               touch,
    input  logic [INDEX_W-1:0] touch_set,
    input  logic [WAY_W-1:0]   touch_way,
    input  logic [INDEX_W-1:0] query_set,
    input  logic [WAYS-1:0]    valid_vec,
    output logic [WAY_W-1:0]   victim_way
);

    generate
        if (WAYS == 1) begin : g_direct
            logic unused_lru;
            assign unused_lru = ^{clk, rst_n, touch, touch_set, touch_way, query_set, valid_vec};
            assign victim_way = '0;
        end else begin : g_assoc
            localparam int AGE_BITS = $clog2(WAYS);

            logic [AGE_BITS-1:0] age_q [SETS][WAYS];

            // Reseed ages to way order on reset; on a touch the way becomes youngest and younger ways age by one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SETS; s++) begin
                        for (int w = 0; w < WAYS; w++) begin
                            age_q[s][w] <= AGE_BITS'(w);
                        end
                    end
                end else if (touch) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (touch_way == WAY_W'(w)) begin
                            age_q[touch_set][w] <= '0;
                        end else if (age_q[touch_set][w] < age_q[touch_set][touch_way]) begin
                            age_q[touch_set][w] <= age_q[touch_set][w] + AGE_BITS'(1);
                        end
                    end
                end
            end

            // Pick the lowest invalid way, otherwise the oldest way of the queried set
            always_comb begin
                logic found;
                victim_way = '0;
                found      = 1'b0;
                for (int w = 0; w < WAYS; w++) begin
                    if (!found && !valid_vec[w]) begin
                        victim_way = WAY_W'(w);
                        found      = 1'b1;
                    end
                end
                if (!found) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (age_q[query_set][w] == AGE_BITS'(WAYS - 1)) begin
                            victim_way = WAY_W'(w);
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/dcache_assoc.sv
// N-way set-associative, write-back, write-allocate L1 data cache.
// Hits are resolved combinationally in IDLE with no added latency; a miss stalls
// the pipeline while an optional dirty-victim writeback and a line fetch run
// on the memory bus, after which the held request re-looks-up and hits.
// Optional build macro DCACHE_ASSOC_PERF_EN adds saturating hit/miss/writeback
// counters; without it the counter ports do not exist.
module dcache_assoc
    import dcache_assoc_pkg::*;
#(
    parameter int WAYS      = DEF_WAYS,
    parameter int SETS      = DEF_SETS,
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int WORD_W    = DEF_WORD_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WORD_W-1:0]    p1_data_i,
    input  logic [ADDR_W-1:0]    p1_addr_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [WORD_W-1:0]    p1_data_o,
    output logic                 p1_stall_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o
`ifdef DCACHE_ASSOC_PERF_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o,
    output logic [31:0]          wb_cnt_o
`endif
);

    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
    localparam int INDEX_BITS  = $clog2(SETS);
    localparam int TAG_BITS    = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int SEL_BITS    = OFFSET_BITS - 2;
    localparam int WORDS       = LINE_BITS / WORD_W;
    localparam int WAY_BITS    = (WAYS > 1) ? $clog2(WAYS) : 1;

    cache_state_t state_q;

    logic                 valid_q [WAYS][SETS];
    logic                 dirty_q [WAYS][SETS];
    logic [TAG_BITS-1:0]  tag_q   [WAYS][SETS];
    logic [LINE_BITS-1:0] line_q  [WAYS][SETS];

    logic [LINE_BITS-1:0] refill_q;
    logic [WAY_BITS-1:0]  victim_q;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [SEL_BITS-1:0]   req_sel;
    logic                  req;
    logic                  hit;
    logic [WAY_BITS-1:0]   hit_way;
    logic                  idle_hit;
    logic                  idle_miss;
    logic [WAYS-1:0]       set_valid;
    logic [WAY_BITS-1:0]   victim_way;
    logic                  victim_dirty;
    logic                  lru_touch;
    logic [WAY_BITS-1:0]   lru_way;
    logic [WORD_W-1:0]     rd_word;
    logic                  unused_addr;

    assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG_BITS];
    assign req_index   = p1_addr_i[OFFSET_BITS +: INDEX_BITS];
    assign req_sel     = p1_addr_i[2 +: SEL_BITS];
    assign unused_addr = ^p1_addr_i[1:0];

    assign req          = p1_MemRead_i | p1_MemWrite_i;
    assign idle_hit     = (state_q == IDLE) && req && hit;
    assign idle_miss    = (state_q == IDLE) && req && !hit;
    assign victim_dirty = valid_q[victim_way][req_index] && dirty_q[victim_way][req_index];

    // Tag compare across all ways of the addressed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_index] && (tag_q[w][req_index] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
    end

    // Gather the valid bits of the addressed set for victim selection
    always_comb begin
        set_valid = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_valid[w] = valid_q[w][req_index];
        end
    end

    // Select the requested word out of the hitting line
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (req_sel == SEL_BITS'(k)) begin
                rd_word = line_q[hit_way][req_index][k*WORD_W +: WORD_W];
            end
        end
    end

    // Stall whenever the request cannot finish this cycle; quiet while reset is held
    always_comb begin
        p1_stall_o = rst_i && ((state_q != IDLE) || (req && !hit));
        p1_data_o  = (rst_i && idle_hit && !p1_MemWrite_i) ? rd_word : '0;
    end

    assign lru_touch = idle_hit || (state_q == REFILL);
    assign lru_way   = (state_q == REFILL) ? victim_q : hit_way;

    dcache_lru_set #(
        .WAYS    (WAYS),
        .SETS    (SETS),
        .WAY_W   (WAY_BITS),
        .INDEX_W (INDEX_BITS)
    ) u_lru (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .touch      (lru_touch),
        .touch_set  (req_index),
        .touch_way  (lru_way),
        .query_set  (req_index),
        .valid_vec  (set_valid),
        .victim_way (victim_way)
    );

    // Line and tag storage plus refill capture; contents need no reset because valid gates them
    always_ff @(posedge clk_i) begin
        if (state_q == ALLOCATE && mem_ack_i) begin
            refill_q <= mem_data_i;
        end
        if (state_q == REFILL) begin
            line_q[victim_q][req_index] <= refill_q;
            tag_q[victim_q][req_index]  <= req_tag;
        end else if (idle_hit && p1_MemWrite_i) begin
            for (int k = 0; k < WORDS; k++) begin
                if (req_sel == SEL_BITS'(k)) begin
                    line_q[hit_way][req_index][k*WORD_W +: WORD_W] <= p1_data_i;
                end
            end
        end
    end

    // Miss-handling FSM with registered memory-bus outputs and valid/dirty bookkeeping
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            victim_q     <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (idle_hit && p1_MemWrite_i) begin
                        dirty_q[hit_way][req_index] <= 1'b1;
                    end else if (idle_miss) begin
                        victim_q     <= victim_way;
                        mem_enable_o <= 1'b1;
                        if (victim_dirty) begin
                            state_q     <= WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {tag_q[victim_way][req_index], req_index, {OFFSET_BITS{1'b0}}};
                            mem_data_o  <= line_q[victim_way][req_index];
                        end else begin
                            state_q     <= ALLOCATE;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= ADDR_W'(line_align(64'(p1_addr_i), OFFSET_BITS));
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_q     <= ALLOCATE;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= ADDR_W'(line_align(64'(p1_addr_i), OFFSET_BITS));
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        state_q      <= REFILL;
                        mem_enable_o <= 1'b0;
                    end
                end
                REFILL: begin
                    valid_q[victim_q][req_index] <= 1'b1;
                    dirty_q[victim_q][req_index] <= 1'b0;
                    state_q                      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_ASSOC_PERF_EN
    logic was_miss_q;

    // Saturating event counters; a hit only counts if the request never stalled
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            wb_cnt_o   <= '0;
            was_miss_q <= 1'b0;
        end else begin
            if (idle_miss) begin
                was_miss_q <= 1'b1;
                if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
            end else if (idle_hit) begin
                was_miss_q <= 1'b0;
                if (!was_miss_q && hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (state_q == WRITEBACK && mem_ack_i && wb_cnt_o != '1) begin
                wb_cnt_o <= wb_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
